control_sequencer: RTL

- Multi-cycle instruction sequencer for the 8080-subset datapath.
- Owns its own step counter and FSM: fetches an opcode into IR, decodes MOV/MVI/ADD/SUB/ANA/ORA/HLT, and drives one-hot register bus-select/load-enable vectors plus the ALU operand/result strobes.
- Replaces the fixed per-register select/enable outputs with parametrised vectors.
- Sits between the IR register and the register file/ALU bus.

---
 rtl/control_pkg.sv | 39 +++
 rtl/control_sequencer_opcode_decoder.sv | 43 ++++
 rtl/control_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared types and constants for the control sequencer and its opcode decoder.
// Optional feature macro: CONTROL_SEQUENCER_ILLEGAL_TRAP_EN (see control_sequencer.sv).
package control_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // ALU operation codes, taken from ooo[2:1] of an ALU opcode
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  // Opcode-class masks: (opcode & MASK) == MATCH
  localparam logic [7:0] MOV_MASK   = 8'hC0;
  localparam logic [7:0] MOV_MATCH  = 8'h40;
  localparam logic [7:0] MVI_MASK   = 8'hC7;
  localparam logic [7:0] MVI_MATCH  = 8'h06;
  localparam logic [7:0] ALU_MASK   = 8'hC0;
  localparam logic [7:0] ALU_MATCH  = 8'h80;
  localparam logic [7:0] HLT_OPCODE = 8'h76;

  // Default register indices
  localparam int DEF_ACC_INDEX = 7;
  localparam int DEF_MEM_INDEX = 6;

  // True when an opcode falls in the class described by mask/match
  function automatic logic opMatch(input logic [7:0] op,
                                   input logic [7:0] mask,
                                   input logic [7:0] match);
    return (op & mask) == match;
  endfunction

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// Combinational opcode classifier: splits IR contents into instruction class,
// register fields and ALU operation. Any use of the M register is illegal.
module opcode_decoder
  import control_pkg::*;
#(
  parameter int REG_FIELD_W = 3,
  parameter int MEM_INDEX   = DEF_MEM_INDEX,
  parameter int ALU_OP_W    = 2
) (
  input  logic [7:0]             ir_data,
  output logic                   is_mov,
  output logic                   is_mvi,
  output logic                   is_alu,
  output logic                   is_hlt,
  output logic                   is_illegal,
  output logic [REG_FIELD_W-1:0] ddd,
  output logic [REG_FIELD_W-1:0] sss,
  output logic [ALU_OP_W-1:0]    alu_op
);

  logic w_dddIsMem;
  logic w_sssIsMem;

  assign ddd = ir_data[5:3];
  assign sss = ir_data[2:0];

  assign w_dddIsMem = (ddd == REG_FIELD_W'(MEM_INDEX));
  assign w_sssIsMem = (sss == REG_FIELD_W'(MEM_INDEX));

  // HLT shares the MOV M,M encoding, so it is carved out of the MOV class
  assign is_hlt = (ir_data == HLT_OPCODE);
  assign is_mov = opMatch(ir_data, MOV_MASK, MOV_MATCH) && !is_hlt &&
                  !w_dddIsMem && !w_sssIsMem;
  assign is_mvi = opMatch(ir_data, MVI_MASK, MVI_MATCH) && !w_dddIsMem;
  // Only the even ooo codes (ADD/SUB/ANA/ORA) are implemented
  assign is_alu = opMatch(ir_data, ALU_MASK, ALU_MATCH) && !ir_data[3] &&
                  !w_sssIsMem;

  assign is_illegal = !(is_mov || is_mvi || is_alu || is_hlt);

  assign alu_op = ALU_OP_W'(ir_data[5:4]);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer for the 8080-subset datapath.
// FETCH loads IR, then EXEC steps 1..3 drive one-hot register select/enable
// vectors and ALU strobes. Outputs are decoded from (state, step, ir_data).
// Optional feature macro: CONTROL_SEQUENCER_ILLEGAL_TRAP_EN adds the 'illegal'
// output and halts on illegal opcodes; without it illegal opcodes act as NOPs.
module control_sequencer
  import control_pkg::*;
#(
  parameter int REG_FIELD_W = 3,
  parameter int NUM_REGS    = 2 ** REG_FIELD_W,
  parameter int ACC_INDEX   = DEF_ACC_INDEX,
  parameter int MEM_INDEX   = DEF_MEM_INDEX,
  parameter int ALU_OP_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [7:0]          ir_data,
  output logic                data_in_select,
  output logic [NUM_REGS-1:0] reg_select,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic                r1_enable,
  output logic                r2_enable,
  output logic                r2_select,
  output logic                ir_enable,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                busy,
  output logic                done,
  output logic                halted,
  output logic [1:0]          step
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  ,
  output logic                illegal
`endif
);

  state_t r_state;
  state_t w_nextState;
  logic [1:0] r_step;
  logic [1:0] w_nextStep;

  logic                   w_isMov;
  logic                   w_isMvi;
  logic                   w_isAlu;
  logic                   w_isHlt;
  logic                   w_isIllegal;
  logic [REG_FIELD_W-1:0] w_ddd;
  logic [REG_FIELD_W-1:0] w_sss;
  logic [ALU_OP_W-1:0]    w_aluOp;

`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  logic r_illegal;
  logic w_trap;
`endif

  opcode_decoder #(
    .REG_FIELD_W(REG_FIELD_W),
    .MEM_INDEX  (MEM_INDEX),
    .ALU_OP_W   (ALU_OP_W)
  ) u_decoder (
    .ir_data   (ir_data),
    .is_mov    (w_isMov),
    .is_mvi    (w_isMvi),
    .is_alu    (w_isAlu),
    .is_hlt    (w_isHlt),
    .is_illegal(w_isIllegal),
    .ddd       (w_ddd),
    .sss       (w_sss),
    .alu_op    (w_aluOp)
  );

  // State and step registers; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_step  <= 2'd0;
    end else begin
      r_state <= w_nextState;
      r_step  <= w_nextStep;
    end
  end

  // Next-state/step and all strobes, decoded from the current state and step
  always_comb begin
    w_nextState    = r_state;
    w_nextStep     = r_step;
    data_in_select = 1'b1;
    reg_select     = '0;
    reg_enable     = '0;
    r1_enable      = 1'b0;
    r2_enable      = 1'b0;
    r2_select      = 1'b0;
    ir_enable      = 1'b0;
    alu_op         = ALU_OP_W'(ALU_ADD);
    done           = 1'b0;
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
    w_trap         = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_nextStep = 2'd0;
        if (run) begin
          w_nextState = FETCH;
        end
      end
      FETCH: begin
        ir_enable   = 1'b1;
        w_nextState = EXEC;
        w_nextStep  = 2'd1;
      end
      EXEC: begin
        // Anything not explicitly continued returns to IDLE, which also
        // recovers from a corrupted step value
        w_nextState = IDLE;
        w_nextStep  = 2'd0;
        if (w_isAlu) begin
          alu_op = w_aluOp;
        end
        case (r_step)
          2'd1: begin
            if (w_isMov) begin
              data_in_select    = 1'b0;
              reg_select[w_sss] = 1'b1;
              reg_enable[w_ddd] = 1'b1;
              done              = 1'b1;
            end else if (w_isMvi) begin
              reg_enable[w_ddd] = 1'b1;
              done              = 1'b1;
            end else if (w_isAlu) begin
              data_in_select        = 1'b0;
              reg_select[ACC_INDEX] = 1'b1;
              r1_enable             = 1'b1;
              w_nextState           = EXEC;
              w_nextStep            = 2'd2;
            end else if (w_isHlt) begin
              done        = 1'b1;
              w_nextState = HALT;
            end else if (w_isIllegal) begin
              done = 1'b1;
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
              w_trap      = 1'b1;
              w_nextState = HALT;
`endif
            end
          end
          2'd2: begin
            if (w_isAlu) begin
              data_in_select    = 1'b0;
              reg_select[w_sss] = 1'b1;
              r2_enable         = 1'b1;
              w_nextState       = EXEC;
              w_nextStep        = 2'd3;
            end
          end
          2'd3: begin
            if (w_isAlu) begin
              data_in_select        = 1'b0;
              r2_select             = 1'b1;
              reg_enable[ACC_INDEX] = 1'b1;
              done                  = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
      HALT: begin
        w_nextStep = 2'd0;
      end
      default: begin
        w_nextState = IDLE;
        w_nextStep  = 2'd0;
      end
    endcase
  end

  assign busy   = (r_state == FETCH) || (r_state == EXEC);
  assign halted = (r_state == HALT);
  assign step   = r_step;

`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  // Sticky trap flag: set when an illegal opcode halts the machine
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if (w_trap) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal || w_trap;
`endif

endmodule
